// File: rtl/gshare_predictor.sv
// Purpose: direction predictor for the fetch stage: table of saturating counters indexed by PC or PC^GHR.
// Latency: lookup is combinational (zero cycles); table, GHR and statistics update at the next clk edge.
// Backpressure: none; a lookup is served every cycle and an update is accepted every cycle.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   pred_valid, pred_pc            fetch lookup request (pred_valid only gates the speculative GHR shift)
//   pred_taken, pred_idx, pred_ghr prediction plus the index and pre-shift GHR carried down the pipe
//   upd_valid, upd_idx, upd_ghr,   resolved-branch update from EX; upd_ghr/upd_taken rebuild the GHR
//   upd_taken, upd_mispredict      when the branch was mispredicted
//   br_cnt, mis_cnt                resolved-branch and mispredict counters since reset (wrap at 2^32)

module gshare_predictor #(
    parameter int IDX_BITS  = 5,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 5,
    parameter int GSHARE    = 1,
    parameter int INIT_CTR  = 0
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_taken,
    output logic [IDX_BITS-1:0]  pred_idx,
    output logic [HIST_BITS-1:0] pred_ghr,

    input  logic                 upd_valid,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,

    output logic [31:0]          br_cnt,
    output logic [31:0]          mis_cnt
);

    localparam int                  DEPTH    = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

    // Pattern history table and speculative global history
    logic [CTR_BITS-1:0]  pht [DEPTH];
    logic [HIST_BITS-1:0] ghr;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] pc_idx;
    logic [IDX_BITS-1:0] hist_ext;
    logic [IDX_BITS-1:0] lookup_idx;

    // Word-aligned PC bits select the entry; bits [1:0] are always zero for
    // 32-bit instructions and carry no information.
    assign pc_idx = pred_pc[IDX_BITS+1:2];

    // History is zero-extended so short histories only perturb the low index bits.
    always_comb begin
        hist_ext                = '0;
        hist_ext[HIST_BITS-1:0] = ghr;
    end

    assign lookup_idx = (GSHARE != 0) ? (pc_idx ^ hist_ext) : pc_idx;

    assign pred_idx   = lookup_idx;
    assign pred_ghr   = ghr;
    assign pred_taken = pht[lookup_idx][CTR_BITS-1];

    // ------------------------------------------------------------------
    // Counter update: saturating step toward the resolved direction.
    // No bypass to the lookup port; a same-cycle read sees the old value.
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0] upd_cur;
    logic [CTR_BITS-1:0] upd_next;

    assign upd_cur = pht[upd_idx];

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) begin
                upd_next = upd_cur + CTR_ONE;
            end
        end else begin
            if (upd_cur != CTR_ZERO) begin
                upd_next = upd_cur - CTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            pht[upd_idx] <= upd_next;
        end
    end

    // ------------------------------------------------------------------
    // Global history
    //   spec_ghr: history after shifting in this cycle's prediction
    //   fix_ghr : history rebuilt from the mispredicted branch's snapshot
    // ------------------------------------------------------------------
    logic [HIST_BITS-1:0] spec_ghr;
    logic [HIST_BITS-1:0] fix_ghr;

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign spec_ghr = pred_taken;
            assign fix_ghr  = upd_taken;
        end else begin : g_hist_many
            assign spec_ghr = {ghr[HIST_BITS-2:0], pred_taken};
            assign fix_ghr  = {upd_ghr[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    logic recover;
    assign recover = upd_valid && upd_mispredict;

    // Recovery wins: a lookup in the same cycle is on the wrong path and
    // will be flushed, so its speculative shift must not survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (recover) begin
            ghr <= fix_ghr;
        end else if (pred_valid) begin
            ghr <= spec_ghr;
        end
    end

    // ------------------------------------------------------------------
    // Statistics (free-running, wrap modulo 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (upd_valid) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (recover) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

    // PC bits outside the index field and the oldest snapshot bit (shifted
    // out on recovery) are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0], upd_ghr[HIST_BITS-1]};

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // default-parameter instance
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [4:0]  pred_idx;
    logic [4:0]  pred_ghr;
    logic        upd_valid;
    logic [4:0]  upd_idx;
    logic [4:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    // swept-parameter instance
    logic        s_pred_valid;
    logic [31:0] s_pred_pc;
    logic        s_pred_taken;
    logic [7:0]  s_pred_idx;
    logic [0:0]  s_pred_ghr;
    logic        s_upd_valid;
    logic [7:0]  s_upd_idx;
    logic [0:0]  s_upd_ghr;
    logic        s_upd_taken;
    logic        s_upd_mispredict;
    logic [31:0] s_br_cnt;
    logic [31:0] s_mis_cnt;

    gshare_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt)
    );

    gshare_predictor #(
        .IDX_BITS (8),
        .CTR_BITS (3),
        .HIST_BITS(1),
        .GSHARE   (0),
        .INIT_CTR (4)
    ) dut_s (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (s_pred_valid),
        .pred_pc        (s_pred_pc),
        .pred_taken     (s_pred_taken),
        .pred_idx       (s_pred_idx),
        .pred_ghr       (s_pred_ghr),
        .upd_valid      (s_upd_valid),
        .upd_idx        (s_upd_idx),
        .upd_ghr        (s_upd_ghr),
        .upd_taken      (s_upd_taken),
        .upd_mispredict (s_upd_mispredict),
        .br_cnt         (s_br_cnt),
        .mis_cnt        (s_mis_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {31'b0, pred_taken};
            1:       return 32'(pred_idx);
            2:       return 32'(pred_ghr);
            3:       return br_cnt;
            4:       return mis_cnt;
            5:       return {31'b0, s_pred_taken};
            6:       return 32'(s_pred_idx);
            7:       return 32'(s_pred_ghr);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model of the default instance
    // ------------------------------------------------------------------
    int          m_ctr [32];
    logic [4:0]  m_ghr;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          model_ok = 1'b0;

    function automatic logic [4:0] m_idx(input logic [31:0] pc);
        logic [4:0] p;
        p = pc[6:2];
        return p ^ m_ghr;
    endfunction

    task automatic model_update();
        logic [4:0] i;
        logic       pt;
        if (reset) begin
            for (int k = 0; k < 32; k++) m_ctr[k] = 0;
            m_ghr    = '0;
            m_br     = '0;
            m_mis    = '0;
            model_ok = 1'b1;
        end else begin
            i  = m_idx(pred_pc);
            pt = (m_ctr[i] >= 2);
            if (upd_valid) begin
                if (upd_taken) begin
                    if (m_ctr[upd_idx] < 3) m_ctr[upd_idx] = m_ctr[upd_idx] + 1;
                end else begin
                    if (m_ctr[upd_idx] > 0) m_ctr[upd_idx] = m_ctr[upd_idx] - 1;
                end
                m_br = m_br + 1;
                if (upd_mispredict) m_mis = m_mis + 1;
            end
            if (upd_valid && upd_mispredict) m_ghr = {upd_ghr[3:0], upd_taken};
            else if (pred_valid)            m_ghr = {m_ghr[3:0], pt};
        end
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance model at posedge.
    task automatic step();
        exp_t       e;
        logic [4:0] i;
        if (model_ok) begin
            i = m_idx(pred_pc);
            push_exp("m_taken", 0, {31'b0, (m_ctr[i] >= 2)});
            push_exp("m_idx",   1, 32'(i));
            push_exp("m_ghr",   2, 32'(m_ghr));
            push_exp("m_br",    3, m_br);
            push_exp("m_mis",   4, m_mis);
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic upd(input logic v, input logic [4:0] idx, input logic t,
                       input logic mis, input logic [4:0] g);
        upd_valid      = v;
        upd_idx        = idx;
        upd_taken      = t;
        upd_mispredict = mis;
        upd_ghr        = g;
    endtask

    task automatic s_upd(input logic v, input logic [7:0] idx, input logic t,
                         input logic mis, input logic g);
        s_upd_valid      = v;
        s_upd_idx        = idx;
        s_upd_taken      = t;
        s_upd_mispredict = mis;
        s_upd_ghr        = g;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        pred_valid   = 1'b0;
        pred_pc      = '0;
        s_pred_valid = 1'b0;
        s_pred_pc    = '0;
        upd(0, 0, 0, 0, 0);
        s_upd(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step();

        // Reset values
        reset   = 1'b0;
        pred_pc = 32'h40;
        push_exp("rst_idx",    1, 32'd16);
        push_exp("rst_taken",  0, 32'd0);
        push_exp("rst_ghr",    2, 32'd0);
        push_exp("rst_br",     3, 32'd0);
        push_exp("rst_mis",    4, 32'd0);
        push_exp("rst_s_take", 5, 32'd1);
        push_exp("rst_s_ghr",  7, 32'd0);
        step();

        // Saturation on idx 3: 0->1->2->3->3->2, then down to 0
        pred_pc = 32'hC;
        upd(1, 3, 1, 0, 0);
        push_exp("sat_idx", 1, 32'd3);
        push_exp("sat_a", 0, 32'd0); step();
        push_exp("sat_b", 0, 32'd0); step();
        push_exp("sat_c", 0, 32'd1); step();
        push_exp("sat_d", 0, 32'd1); step();
        upd(1, 3, 0, 0, 0);
        push_exp("sat_e", 0, 32'd1); step();
        push_exp("sat_f", 0, 32'd1); step();
        step();
        step();
        upd(0, 0, 0, 0, 0);
        push_exp("sat_zero", 0, 32'd0); step();

        // Prime idx 16 and 18 to weakly taken
        upd(1, 16, 1, 0, 0); step(); step();
        upd(1, 18, 1, 0, 0); step(); step();
        upd(0, 0, 0, 0, 0);

        // GHR speculation: predictions T, N, T
        pred_pc    = 32'h40;
        pred_valid = 1'b1;
        push_exp("spec0_ghr", 2, 32'd0); push_exp("spec0_t", 0, 32'd1); push_exp("spec0_i", 1, 32'd16); step();
        push_exp("spec1_ghr", 2, 32'd1); push_exp("spec1_t", 0, 32'd0); push_exp("spec1_i", 1, 32'd17); step();
        push_exp("spec2_ghr", 2, 32'd2); push_exp("spec2_t", 0, 32'd1); push_exp("spec2_i", 1, 32'd18); step();

        // Recovery beats the simultaneous speculative shift
        upd(1, 9, 1, 1, 5'b10110);
        push_exp("spec3_ghr", 2, 32'd5);
        push_exp("spec3_idx", 1, 32'd21);
        push_exp("rec_br0",   3, 32'd12);
        push_exp("rec_mis0",  4, 32'd0);
        step();
        pred_valid = 1'b0;
        upd(0, 0, 0, 0, 0);
        push_exp("rec_ghr", 2, 32'h0D);
        push_exp("rec_br",  3, 32'd13);
        push_exp("rec_mis", 4, 32'd1);
        step();

        // Same-cycle hazard on idx 7 (pc idx 10 ^ ghr 13)
        pred_pc = 32'h28;
        upd(1, 7, 1, 0, 0);
        push_exp("haz_idx", 1, 32'd7);
        push_exp("haz_pre", 0, 32'd0); step();
        push_exp("haz_same", 0, 32'd0); step();
        upd(0, 0, 0, 0, 0);
        push_exp("haz_next", 0, 32'd1); step();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            pred_valid = 1'($urandom_range(0, 1));
            pred_pc    = $urandom;
            upd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
            step();
        end

        // Reset mid-stream with an update and lookup in flight
        reset      = 1'b1;
        pred_valid = 1'b1;
        upd(1, 7, 1, 1, 5'b11111);
        step();
        reset      = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = 32'h1C;
        upd(0, 0, 0, 0, 0);
        push_exp("mid_ghr",   2, 32'd0);
        push_exp("mid_br",    3, 32'd0);
        push_exp("mid_mis",   4, 32'd0);
        push_exp("mid_idx",   1, 32'd7);
        push_exp("mid_taken", 0, 32'd0);
        step();

        // Swept instance: 3-bit counters from 4, 1-bit history, bimodal
        s_pred_pc    = 32'h54;
        s_pred_valid = 1'b1;
        s_upd(1, 21, 0, 0, 0);
        push_exp("sw0_t", 5, 32'd1); push_exp("sw0_i", 6, 32'd21); push_exp("sw0_g", 7, 32'd0); step();
        s_pred_valid = 1'b0;
        push_exp("sw1_t", 5, 32'd0); push_exp("sw1_i", 6, 32'd21); push_exp("sw1_g", 7, 32'd1); step();
        step();
        step();
        step();
        s_upd(1, 21, 1, 0, 0);
        push_exp("sw5_floor", 5, 32'd0); step();
        step();
        push_exp("sw7_t", 5, 32'd0); step();
        step();
        s_upd(0, 0, 0, 0, 0);
        push_exp("sw9_t", 5, 32'd1); step();
        s_upd(1, 99, 0, 1, 1);
        push_exp("sw10_g", 7, 32'd1); step();
        s_upd(0, 0, 0, 0, 0);
        push_exp("sw11_g", 7, 32'd0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised direction predictor for the pipelined RISC-V core's fetch stage. It replaces the fixed 32-entry, 2-bit, PC-indexed pattern history table with a table of configurable depth and counter width. The table can be indexed bimodally or in gshare mode (PC XOR global history). It keeps a speculative global history register (GHR) that is repaired on mispredict, and counts resolved branches and mispredicts for performance analysis.

## Interface
- IDX_BITS, 5, log2 of table depth (table has 2^IDX_BITS counters)
- CTR_BITS, 2, saturating counter width, 1..4
- HIST_BITS, 5, GHR width, 1..IDX_BITS
- GSHARE, 1, 1 = index is PC XOR GHR; 0 = PC only, GHR still maintained
- INIT_CTR, 0, reset value of every counter, must be < 2^CTR_BITS
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pred_valid  in  1  fetch is looking up a branch this cycle
- pred_pc  in  32  fetch PC
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_BITS  table index used; carried down the pipe
- pred_ghr  out  HIST_BITS  GHR value before this prediction; carried down the pipe
- upd_valid  in  1  a branch resolved in EX this cycle
- upd_idx  in  IDX_BITS  pred_idx carried with that branch
- upd_ghr  in  HIST_BITS  pred_ghr carried with that branch
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  predicted direction was wrong; qualified by upd_valid
- br_cnt  out  32  resolved branches since reset
- mis_cnt  out  32  mispredicts since reset

## Operation
- Index:
  - h is the GHR zero-extended to IDX_BITS.
  - gshare mode: idx = pred_pc[IDX_BITS+1:2] ^ h.
  - bimodal mode: idx = pred_pc[IDX_BITS+1:2].
- Prediction: pred_taken = MSB of counter[idx].
- pred_idx, pred_ghr and pred_taken are driven every cycle, regardless of pred_valid.
- Counter update on upd_valid, applied to counter[upd_idx]:
  - taken: increment, saturating at 2^CTR_BITS-1.
  - not taken: decrement, saturating at 0.
  - No wrap-around in either direction.
- GHR is a shift register; the newest outcome enters at bit 0.
  - Speculative shift: on pred_valid with no mispredict this cycle, GHR <= {GHR[HIST_BITS-2:0], pred_taken}.
  - Recovery: on upd_valid && upd_mispredict, GHR <= {upd_ghr[HIST_BITS-2:0], upd_taken}.
  - HIST_BITS=1: the new GHR is just the incoming bit.
- Recovery takes priority over a simultaneous speculative shift. The same-cycle lookup belongs to the wrong path and is flushed by the core, so its shift is dropped.
- Statistics:
  - br_cnt increments on every upd_valid.
  - mis_cnt increments on upd_valid && upd_mispredict.
  - Both wrap modulo 2^32.
- Reset: all counters <= INIT_CTR, GHR <= 0, br_cnt <= 0, mis_cnt <= 0.
- Reset overrides any pending update or lookup in the same cycle.

## Timing
- Lookup is combinational, zero latency. Outputs reflect table and GHR state as of the last clock edge.
- Counter update, GHR update and counter statistics all take effect at the posedge.
- Same-cycle update and lookup of the same index: lookup returns the pre-update value. There is no bypass. The new value is visible from the next cycle.
- Back-to-back updates to the same index accumulate, one step per cycle.
- Output values after reset:
  - pred_taken = MSB of INIT_CTR.
  - pred_ghr = 0.
  - pred_idx = pred_pc[IDX_BITS+1:2].
  - br_cnt = mis_cnt = 0.
- Reset asserted mid-stream: on the cycle after reset, every counter and the GHR are at reset values, regardless of in-flight updates.

## Test plan
- Reset, then a lookup with defaults and pred_pc=0x40: pred_idx=16, pred_taken=0, pred_ghr=0, br_cnt=0.
- Saturation: 4x update idx 3 taken, then 1x not taken (counter 0→1→2→3→3→2). pred_taken on idx 3 reads 0,0,1,1,1,1 on successive cycles; after 3x more not-taken the counter is 0 and pred_taken=0.
- GHR speculation: pred_valid for 3 cycles with predicted taken, 0, taken. pred_ghr reads 00000, 00001, 00010, then 00101. In gshare mode at pred_pc=0x40, pred_idx=16^5=21.
- Recovery priority: pred_valid=1 and upd_valid=upd_mispredict=1 in the same cycle, with upd_ghr=5'b10110 and upd_taken=1. Next-cycle pred_ghr=5'b01101; mis_cnt increments by 1 and br_cnt by 1.
- Same-cycle hazard: counter[7]=1, upd idx 7 taken while looking up idx 7. pred_taken=0 that cycle, 1 the next.
- Parameter sweep: IDX_BITS=8, CTR_BITS=3, HIST_BITS=1, GSHARE=0, INIT_CTR=4. After reset pred_taken=1; 5 not-taken updates on one index drive it from 4 to 0 with pred_taken going 0 after the first update; pred_idx ignores the GHR.
